// File: rtl/serial_add_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : serial_add_pkg                                               |
// | Description : State encoding and digit-count helpers for serial_add.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package serial_add_pkg;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    // Number of W-bit digits in an N-bit operand.
    function automatic int digit_count(input int n, input int w);
        return n / w;
    endfunction

    // One spare bit so the counter can represent the digit count itself.
    function automatic int count_width(input int n, input int w);
        return $clog2(n / w) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_add_digit_add.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : digit_add                                                    |
// | Description : W-bit ripple-carry adder, also exposing the carry into MSB.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module digit_add #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_ci,
    output logic [W-1:0] o_s,
    output logic         o_co,
    output logic         o_c_msb
);

    logic [W:0] w_c;

    assign w_c[0] = i_ci;

    generate
        for (genvar i = 0; i < W; i++) begin : g_bit
            assign o_s[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
            assign w_c[i+1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
        end
    endgenerate

    assign o_co    = w_c[W];
    assign o_c_msb = w_c[W-1];

endmodule
`default_nettype wire

// File: rtl/serial_add.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : serial_add                                                   |
// | Description : Digit-serial add/subtract, W bits per cycle, valid/ready IO. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module serial_add
    import serial_add_pkg::*;
#(
    parameter int N = 32,
    parameter int M = N,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [M-1:0] B,
    input  logic         CI,
    input  logic         SUB,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] S,
    output logic         CO,
    output logic         OV
);

    localparam int c_digits = digit_count(N, W);
    localparam int c_cw     = count_width(N, W);
    localparam int c_iw     = (N > 1) ? $clog2(N) : 1;
    localparam logic [c_cw-1:0] c_last = c_cw'(c_digits - 1);

    generate
        if ((M > N) || (M < 1) || (W < 1) || (W > N) || ((N % W) != 0)) begin : g_param_error
            $error("serial_add: illegal parameters N=%0d M=%0d W=%0d", N, M, W);
        end
    endgenerate

    logic [1:0]      r_state;
    logic [c_cw-1:0] r_cnt;
    logic [N-1:0]    r_a;
    logic [N-1:0]    r_b;
    logic            r_c;
    logic [N-1:0]    r_s;
    logic            r_co;
    logic            r_ov;

    logic [N-1:0]    w_b_ext;
    logic [c_iw-1:0] w_base;
    logic [W-1:0]    w_a_dig;
    logic [W-1:0]    w_b_dig;
    logic [W-1:0]    w_sum;
    logic            w_co;
    logic            w_c_msb;
    logic            w_in_ready;
    logic            w_accept;
    logic            w_last;

    assign w_b_ext    = N'(B);
    assign w_base     = c_iw'(int'(r_cnt) * W);
    assign w_a_dig    = r_a[w_base +: W];
    assign w_b_dig    = r_b[w_base +: W];
    assign w_last     = (r_cnt == c_last);
    assign w_in_ready = (r_state == c_st_idle) || ((r_state == c_st_done) && out_ready);
    assign w_accept   = in_valid && w_in_ready;

    digit_add #(
        .W (W)
    ) u_digit_add (
        .i_a     (w_a_dig),
        .i_b     (w_b_dig),
        .i_ci    (r_c),
        .o_s     (w_sum),
        .o_co    (w_co),
        .o_c_msb (w_c_msb)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= 1'b0;
            r_s     <= '0;
            r_co    <= 1'b0;
            r_ov    <= 1'b0;
        end else if (w_accept) begin
            // Subtraction is A + ~B + 1; the carry-in is forced so CI is ignored.
            r_a     <= A;
            r_b     <= SUB ? ~w_b_ext : w_b_ext;
            r_c     <= SUB ? 1'b1 : CI;
            r_cnt   <= '0;
            r_state <= c_st_run;
        end else begin
            case (r_state)
                c_st_run: begin
                    r_s[w_base +: W] <= w_sum;
                    r_c              <= w_co;
                    if (w_last) begin
                        r_co    <= w_co;
                        r_ov    <= w_c_msb ^ w_co;
                        r_state <= c_st_done;
                    end else begin
                        r_cnt <= r_cnt + c_cw'(1);
                    end
                end
                c_st_done: begin
                    if (out_ready) begin
                        r_state <= c_st_idle;
                    end
                end
                c_st_idle: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = (r_state == c_st_done);
    assign S         = r_s;
    assign CO        = r_co;
    assign OV        = r_ov;

endmodule
`default_nettype wire

// File: tb/tb_serial_add.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_serial_add                                                |
// | Description : Self-checking bench for serial_add with result scoreboards.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_serial_add;

    typedef logic [65:0] res_t;   // {co, ov, s[63:0]}

    localparam int NOPS = 250;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // N=8, W=2 main instance
    logic [7:0] a0 = '0, b0 = '0, s0;
    logic       ci0 = 1'b0, sub0 = 1'b0, iv0 = 1'b0, ordy0 = 1'b1;
    logic       ir0, ovld0, co0, ovf0;

    // N=8, M=4, W=2 instance
    logic [7:0] a1 = '0, s1;
    logic [3:0] b1 = '0;
    logic       ci1 = 1'b0, sub1 = 1'b0, iv1 = 1'b0, ordy1 = 1'b1;
    logic       ir1, ovld1, co1, ovf1;

    // N=64 instances with W = 1, 8, 64 sharing operands
    logic [63:0] a64 = '0, b64 = '0;
    logic        ci64 = 1'b0, sub64 = 1'b0;
    logic        iv64 [3] = '{1'b0, 1'b0, 1'b0};
    logic        ordy64 [3] = '{1'b1, 1'b1, 1'b1};
    logic        ir64 [3], ovld64 [3], co64 [3], ovf64 [3];
    logic [63:0] s64 [3];

    res_t sb0 [$];
    res_t sb64 [$];
    int   rd64 [3] = '{0, 0, 0};

    serial_add #(.N(8), .M(8), .W(2)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .A(a0), .B(b0),
        .CI(ci0), .SUB(sub0), .out_valid(ovld0), .out_ready(ordy0),
        .S(s0), .CO(co0), .OV(ovf0)
    );

    serial_add #(.N(8), .M(4), .W(2)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .A(a1), .B(b1),
        .CI(ci1), .SUB(sub1), .out_valid(ovld1), .out_ready(ordy1),
        .S(s1), .CO(co1), .OV(ovf1)
    );

    generate
        for (genvar g = 0; g < 3; g++) begin : g_w64
            serial_add #(.N(64), .M(64), .W((g == 0) ? 1 : (g == 1) ? 8 : 64)) u_dut (
                .clk(clk), .rst(rst), .in_valid(iv64[g]), .in_ready(ir64[g]),
                .A(a64), .B(b64), .CI(ci64), .SUB(sub64),
                .out_valid(ovld64[g]), .out_ready(ordy64[g]),
                .S(s64[g]), .CO(co64[g]), .OV(ovf64[g])
            );
        end
    endgenerate

    function automatic res_t ref_add(input logic [63:0] a, input logic [63:0] b,
                                     input logic ci, input logic sub, input int n);
        logic [64:0] m65, sum;
        logic [63:0] mask, aa, bb, s;
        logic        co, ovf;
        m65  = (65'd1 << n) - 65'd1;
        mask = m65[63:0];
        aa   = a & mask;
        bb   = sub ? (~b & mask) : (b & mask);
        sum  = {1'b0, aa} + {1'b0, bb} + {64'd0, (sub | ci)};
        s    = sum[63:0] & mask;
        co   = sum[n];
        ovf  = (aa[n-1] == bb[n-1]) && (s[n-1] != aa[n-1]);
        return {co, ovf, s};
    endfunction

    task automatic check(input string tag, input res_t obs, input res_t exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Result monitors: pop the expected value when a result is handed over.
    always @(negedge clk) begin
        res_t e;
        if (rst && ovld0 && ordy0) begin
            if (sb0.size() == 0) begin
                check("dut0_unexpected_result", 66'd1, 66'd0);
            end else begin
                e = sb0.pop_front();
                check("dut0_result", {co0, ovf0, 56'd0, s0}, e);
            end
        end
        for (int j = 0; j < 3; j++) begin
            if (rst && ovld64[j] && ordy64[j]) begin
                if (rd64[j] >= sb64.size()) begin
                    check($sformatf("w64_%0d_unexpected_result", j), 66'd1, 66'd0);
                end else begin
                    check($sformatf("w64_%0d_result_op%0d", j, rd64[j]),
                          {co64[j], ovf64[j], s64[j]}, sb64[rd64[j]]);
                end
                rd64[j]++;
            end
        end
    end

    // Present operands on u_dut0 and wait for acceptance; entered at posedge+1.
    task automatic send0(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic sub);
        int guard = 0;
        a0 = a; b0 = b; ci0 = ci; sub0 = sub; iv0 = 1'b1;
        @(negedge clk);
        while (!ir0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!ir0) check("send0_accept_timeout", 66'd0, 66'd1);
        else      sb0.push_back(ref_add({56'd0, a}, {56'd0, b}, ci, sub, 8));
        @(posedge clk); #1;
        iv0 = 1'b0;
    endtask

    task automatic wait_out0(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ovld0 && lat < 40);
    endtask

    task automatic run1(input logic [7:0] a, input logic [3:0] b, input logic sub, input string tag);
        int   guard = 0;
        res_t e;
        e  = ref_add({56'd0, a}, {60'd0, b}, 1'b0, sub, 8);
        a1 = a; b1 = b; sub1 = sub; iv1 = 1'b1;
        @(negedge clk);
        while (!ir1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk); #1;
        iv1   = 1'b0;
        guard = 0;
        @(negedge clk);
        while (!ovld1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check(tag, {co1, ovf1, 56'd0, s1}, e);
        @(posedge clk); #1;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat;
        int         guard;
        logic [7:0] hold_s;
        logic [1:0] hold_f;
        logic       acc [3];
        logic [7:0] tab_a   [7] = '{8'hFF, 8'h05, 8'h07, 8'h7F, 8'h07, 8'h10, 8'h80};
        logic [7:0] tab_b   [7] = '{8'h01, 8'h07, 8'h05, 8'h01, 8'h05, 8'h20, 8'h7F};
        logic       tab_ci  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic       tab_sub [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        // Reset state and first-cycle readiness.
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {56'd0, ovld0, co0, ovf0, s0}, 66'd0);
        check("reset_in_ready", {65'd0, ir0}, 66'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_reset", {65'd0, ir0}, 66'd1);
        @(posedge clk); #1;

        // Directed operations, each with accept-to-out_valid latency of 5.
        for (int i = 0; i < 7; i++) begin
            send0(tab_a[i], tab_b[i], tab_ci[i], tab_sub[i]);
            wait_out0(lat);
            check($sformatf("latency_op%0d", i), 66'(lat), 66'd5);
            @(posedge clk); #1;
        end

        // Backpressure: result and flags hold while out_ready is low.
        ordy0 = 1'b0;
        send0(8'h33, 8'h44, 1'b0, 1'b0);
        wait_out0(lat);
        hold_s = s0;
        hold_f = {co0, ovf0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold", {54'd0, hold_f, ovld0, ir0, s0}, {54'd0, hold_f, 1'b1, 1'b0, hold_s});
        end
        check("bp_value", {56'd0, hold_f, s0}, {56'd0, 2'b00, 8'h77});
        @(posedge clk); #1;
        ordy0 = 1'b1;
        a0 = 8'h80; b0 = 8'h80; ci0 = 1'b0; sub0 = 1'b0; iv0 = 1'b1;
        @(negedge clk);
        check("b2b_in_ready", {65'd0, ir0}, 66'd1);
        sb0.push_back(ref_add(64'h80, 64'h80, 1'b0, 1'b0, 8));
        @(posedge clk); #1;
        iv0 = 1'b0;
        @(negedge clk);
        check("b2b_no_idle", {64'd0, ovld0, ir0}, 66'd0);
        wait_out0(lat);
        check("b2b_latency", 66'(lat), 66'd4);
        @(posedge clk); #1;

        // Asynchronous reset while digit 2 is in progress.
        send0(8'h5A, 8'h25, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        check("partial_sum", {58'd0, s0}, 66'h0F);
        rst = 1'b0;
        sb0.delete();
        #1;
        check("rst_async_outputs", {56'd0, ovld0, co0, ovf0, s0}, 66'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_release_ready", {65'd0, ir0}, 66'd1);
        @(posedge clk); #1;
        send0(8'h12, 8'h34, 1'b0, 1'b0);
        wait_out0(lat);
        check("post_reset_latency", 66'(lat), 66'd5);
        @(posedge clk); #1;

        // Narrow B operand is zero-extended before any inversion.
        run1(8'h10, 4'hF, 1'b0, "m4_add");
        run1(8'h10, 4'hF, 1'b1, "m4_sub");

        // Randomised 64-bit traffic on W = 1, 8, 64 with random backpressure.
        for (int op = 0; op < NOPS; op++) begin
            case (op)
                0:       begin a64 = '1;                    b64 = 64'd1; ci64 = 1'b0; sub64 = 1'b0; end
                1:       begin a64 = 64'h8000_0000_0000_0000; b64 = 64'd1; ci64 = 1'b0; sub64 = 1'b1; end
                2:       begin a64 = '0;                    b64 = '0;    ci64 = 1'b1; sub64 = 1'b1; end
                3:       begin a64 = 64'h7FFF_FFFF_FFFF_FFFF; b64 = 64'd0; ci64 = 1'b1; sub64 = 1'b0; end
                default: begin
                    a64   = {$urandom, $urandom};
                    b64   = {$urandom, $urandom};
                    ci64  = 1'($urandom_range(0, 1));
                    sub64 = 1'($urandom_range(0, 1));
                end
            endcase
            sb64.push_back(ref_add(a64, b64, ci64, sub64, 64));
            for (int j = 0; j < 3; j++) iv64[j] = 1'b1;
            guard = 0;
            while ((iv64[0] || iv64[1] || iv64[2]) && guard < 400) begin
                @(negedge clk);
                for (int j = 0; j < 3; j++) acc[j] = iv64[j] && ir64[j];
                @(posedge clk); #1;
                for (int j = 0; j < 3; j++) begin
                    if (acc[j]) iv64[j] = 1'b0;
                    ordy64[j] = ($urandom_range(0, 3) != 0);
                end
                guard++;
            end
            if (guard >= 400) check($sformatf("w64_accept_timeout_op%0d", op), 66'd0, 66'd1);
        end
        for (int j = 0; j < 3; j++) ordy64[j] = 1'b1;
        guard = 0;
        while ((rd64[0] < NOPS || rd64[1] < NOPS || rd64[2] < NOPS) && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        for (int j = 0; j < 3; j++) check($sformatf("w64_%0d_drained", j), 66'(rd64[j]), 66'(NOPS));
        check("dut0_scoreboard_empty", 66'(sb0.size()), 66'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
